// File: rtl/relay_framer.sv
// HF relay framer: symbol history FSM, symbol FIFO and MSB-first serializer.
// Optional idle frame timeout is compiled in when RELAY_FRAMER_TIMEOUT_EN is defined.
module relay_framer #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_LOG2   = 4,
    parameter int TIMEOUT_W  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hi_simulate_mod_type,
    input  logic [3:0] sym_in,
    input  logic       sym_valid,
    output logic [2:0] mod_type,
    output logic       data_out,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow,
    output logic       timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] ROLE_RDR = 3'b101;
    localparam logic [2:0] ROLE_TAG = 3'b110;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DIV_LOG2 < 1 || TIMEOUT_W < 1) begin : g_bad_param
        $error("relay_framer: illegal parameter value");
    end

    typedef enum logic {ST_LISTEN, ST_MOD} state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [2:0]    r_role;
    logic [19:0]   r_hist;
    logic [19:0]   w_hist_n;
    logic          r_par;
    logic          w_par_n;
    logic [2:0]    r_mod;
    logic [2:0]    w_mod_n;

    logic          w_active;
    logic          w_role_chg;
    logic          w_flush;
    logic          w_hold;
    logic          w_accept;
    logic          w_idle;
    logic          w_is_rdr;
    logic [19:0]   w_h_upd;
    logic          w_p_upd;
    logic          w_start;
    logic          w_end;
    logic [2:0]    w_listen_code;
    logic [2:0]    w_mod_code;

`ifdef RELAY_FRAMER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_n;
    logic                 r_to;
    logic                 w_to_n;
`endif

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_n;
    logic          r_empty;
    logic          r_full;
    logic          r_ovf;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;

    logic                r_busy;
    logic [3:0]          r_shift;
    logic [DIV_LOG2-1:0] r_div;
    logic [1:0]          r_bit;
    logic                r_dout;
    logic                w_last;

    assign w_active   = (hi_simulate_mod_type == ROLE_RDR) ||
                        (hi_simulate_mod_type == ROLE_TAG);
    assign w_role_chg = hi_simulate_mod_type != r_role;
    assign w_flush    = w_role_chg || !w_active;
    assign w_hold     = !w_role_chg && !w_active;
    assign w_accept   = sym_valid && w_active && !w_role_chg;
    assign w_idle     = !sym_valid && w_active && !w_role_chg;
    assign w_is_rdr   = hi_simulate_mod_type == ROLE_RDR;

    assign w_h_upd = {r_hist[15:0], sym_in};
    assign w_p_upd = ~r_par;

    assign w_start = w_is_rdr ? (w_h_upd == 20'h0000C)
                              : (w_h_upd == 20'h0000F);
    assign w_end   = w_is_rdr
                   ? ((w_h_upd == 20'h00000 || w_h_upd == 20'hC0000) && !w_p_upd)
                   : ((w_h_upd[11:0] == 12'h000) && !w_p_upd);

    assign w_listen_code = w_is_rdr ? 3'b011 : 3'b001;
    assign w_mod_code    = w_is_rdr ? 3'b100 : 3'b010;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LISTEN;
            r_role  <= 3'b000;
            r_hist  <= 20'h00000;
            r_par   <= 1'b0;
            r_mod   <= 3'b000;
`ifdef RELAY_FRAMER_TIMEOUT_EN
            r_cnt   <= '0;
            r_to    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_role  <= hi_simulate_mod_type;
            r_hist  <= w_hist_n;
            r_par   <= w_par_n;
            r_mod   <= w_mod_n;
`ifdef RELAY_FRAMER_TIMEOUT_EN
            r_cnt   <= w_cnt_n;
            r_to    <= w_to_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_par_n   = r_par;
        w_mod_n   = r_mod;
`ifdef RELAY_FRAMER_TIMEOUT_EN
        w_cnt_n   = '0;
        w_to_n    = 1'b0;
`endif
        unique case (1'b1)
            w_role_chg: begin
                w_state_n = ST_LISTEN;
                w_hist_n  = 20'h00000;
                w_par_n   = 1'b0;
                w_mod_n   = w_active ? w_listen_code : 3'b000;
            end
            w_hold: begin
                w_state_n = ST_LISTEN;
                w_hist_n  = 20'h00000;
                w_par_n   = 1'b0;
            end
            w_accept: begin
                w_hist_n = w_h_upd;
                w_par_n  = w_p_upd;
                if (w_start) begin
                    w_state_n = ST_MOD;
                    w_par_n   = 1'b0;
                    w_mod_n   = w_mod_code;
                end else if (r_state == ST_MOD && w_end) begin
                    w_state_n = ST_LISTEN;
                    w_mod_n   = w_listen_code;
                end
            end
            w_idle: begin
`ifdef RELAY_FRAMER_TIMEOUT_EN
                if (r_state == ST_MOD) begin
                    if (r_cnt == '1) begin
                        w_state_n = ST_LISTEN;
                        w_par_n   = 1'b0;
                        w_mod_n   = w_listen_code;
                        w_to_n    = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + TIMEOUT_W'(1);
                    end
                end
`endif
            end
            default: ;
        endcase
    end

    // A full FIFO still takes a push when the serializer drains it that cycle.
    assign w_last = r_busy && (r_div == '1) && (r_bit == 2'd3);
    assign w_pop  = !r_empty && (!r_busy || w_last);
    assign w_push = w_accept && (!r_full || w_pop);
    assign w_drop = w_accept && r_full && !w_pop;

    always_comb begin
        w_count_n = r_count;
        if (w_push && !w_pop) begin
            w_count_n = r_count + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_n = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= sym_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_n;
            r_empty <= w_count_n == '0;
            r_full  <= w_count_n == FULL_CNT;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // data_out trails the shift register by one cycle so the MSB of a
    // symbol popped at cycle n+1 shows at n+2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_shift <= 4'h0;
            r_div   <= '0;
            r_bit   <= 2'd0;
            r_dout  <= 1'b0;
        end else if (w_flush) begin
            r_busy  <= 1'b0;
            r_shift <= 4'h0;
            r_div   <= '0;
            r_bit   <= 2'd0;
            r_dout  <= 1'b0;
        end else begin
            r_dout <= r_busy & r_shift[3];
            if (w_pop) begin
                r_busy  <= 1'b1;
                r_shift <= r_mem[r_rptr];
                r_div   <= '0;
                r_bit   <= 2'd0;
            end else if (w_last) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_div <= r_div + DIV_LOG2'(1);
                if (r_div == '1) begin
                    r_shift <= {r_shift[2:0], 1'b0};
                    r_bit   <= r_bit + 2'd1;
                end
            end
        end
    end

    assign mod_type   = r_mod;
    assign data_out   = r_dout;
    assign fifo_empty = r_empty;
    assign fifo_full  = r_full;
    assign overflow   = r_ovf;
`ifdef RELAY_FRAMER_TIMEOUT_EN
    assign timeout    = r_to;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_relay_framer.sv
// Testbench for relay_framer: FSM vector table, serializer scoreboard,
// FIFO boundaries, idle timeout and asynchronous reset.
module tb_relay_framer;

    localparam int DEPTH = 4;
    localparam int DLOG  = 2;
    localparam int TOW   = 4;
    localparam int BITP  = 1 << DLOG;

    logic       clk;
    logic       rst_n;
    logic [2:0] role;
    logic [3:0] sym;
    logic       vld;
    logic [2:0] mod_type;
    logic       data_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       timeout;

    int checks;
    int failures;

    typedef struct packed {
        logic [2:0] role;
        logic [3:0] sym;
        logic       vld;
        logic [2:0] exp_mod;
    } vec_t;

    vec_t       tbl[$];
    logic [2:0] q_mod[$];
    logic       q_bit[$];

    relay_framer #(
        .FIFO_DEPTH(DEPTH),
        .DIV_LOG2  (DLOG),
        .TIMEOUT_W (TOW)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .hi_simulate_mod_type(role),
        .sym_in              (sym),
        .sym_valid           (vld),
        .mod_type            (mod_type),
        .data_out            (data_out),
        .fifo_empty          (fifo_empty),
        .fifo_full           (fifo_full),
        .overflow            (overflow),
        .timeout             (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym_bits(input logic [3:0] s);
        for (int b = 3; b >= 0; b--) begin
            repeat (BITP) q_bit.push_back(s[b]);
        end
    endtask

    task automatic drain_bits(input string tag);
        int idx;
        idx = 0;
        while (q_bit.size() > 0) begin
            tick();
            check($sformatf("%s_c%0d", tag, idx), data_out, q_bit.pop_front());
            idx++;
        end
    endtask

    task automatic set_role(input logic [2:0] r);
        role = r;
        vld  = 1'b0;
        tick();
    endtask

    task automatic send(input logic [3:0] s);
        sym = s;
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    initial begin
        int k;
        bit fired;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        role  = 3'b000;
        sym   = 4'h0;
        vld   = 1'b0;

        tbl.push_back('{3'b101, 4'h0, 1'b0, 3'b011});
        tbl.push_back('{3'b101, 4'hC, 1'b1, 3'b100});
        tbl.push_back('{3'b101, 4'hA, 1'b1, 3'b100});
        tbl.push_back('{3'b101, 4'h5, 1'b1, 3'b100});
        for (int i = 0; i < 5; i++) tbl.push_back('{3'b101, 4'h0, 1'b1, 3'b100});
        tbl.push_back('{3'b101, 4'h0, 1'b1, 3'b011});
        tbl.push_back('{3'b101, 4'h0, 1'b0, 3'b011});
        tbl.push_back('{3'b101, 4'hC, 1'b1, 3'b100});
        for (int i = 0; i < 3; i++) tbl.push_back('{3'b101, 4'h0, 1'b1, 3'b100});
        tbl.push_back('{3'b101, 4'h0, 1'b1, 3'b011});
        tbl.push_back('{3'b110, 4'h0, 1'b0, 3'b001});
        tbl.push_back('{3'b110, 4'hF, 1'b1, 3'b010});
        tbl.push_back('{3'b110, 4'h3, 1'b1, 3'b010});
        tbl.push_back('{3'b110, 4'h0, 1'b1, 3'b010});
        tbl.push_back('{3'b110, 4'h0, 1'b1, 3'b010});
        tbl.push_back('{3'b110, 4'h0, 1'b1, 3'b001});
        tbl.push_back('{3'b110, 4'hF, 1'b1, 3'b001});
        tbl.push_back('{3'b000, 4'h0, 1'b0, 3'b000});
        tbl.push_back('{3'b110, 4'h0, 1'b0, 3'b001});
        tbl.push_back('{3'b110, 4'hF, 1'b1, 3'b010});
        for (int i = 0; i < 3; i++) tbl.push_back('{3'b110, 4'h0, 1'b1, 3'b010});
        tbl.push_back('{3'b110, 4'h0, 1'b1, 3'b001});
        tbl.push_back('{3'b000, 4'h0, 1'b0, 3'b000});
        tbl.push_back('{3'b000, 4'hC, 1'b1, 3'b000});
        tbl.push_back('{3'b101, 4'h0, 1'b0, 3'b011});
        tbl.push_back('{3'b101, 4'hC, 1'b1, 3'b100});
        tbl.push_back('{3'b000, 4'h0, 1'b0, 3'b000});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mod_type", mod_type, 3'b000);
        check("rst_data_out", data_out, 1'b0);
        check("rst_fifo_empty", fifo_empty, 1'b1);
        check("rst_fifo_full", fifo_full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            role = tbl[i].role;
            sym  = tbl[i].sym;
            vld  = tbl[i].vld;
            q_mod.push_back(tbl[i].exp_mod);
            tick();
            check($sformatf("vec%0d_mod_type", i), mod_type, q_mod.pop_front());
        end
        vld = 1'b0;

        set_role(3'b000);
        set_role(3'b101);
        send(4'hA);
        check("ser1_not_empty", fifo_empty, 1'b0);
        q_bit.push_back(1'b0);
        push_sym_bits(4'hA);
        q_bit.push_back(1'b0);
        q_bit.push_back(1'b0);
        drain_bits("ser1");

        send(4'h9);
        send(4'h6);
        check("ser2_pop_cycle", data_out, 1'b0);
        push_sym_bits(4'h9);
        push_sym_bits(4'h6);
        q_bit.push_back(1'b0);
        q_bit.push_back(1'b0);
        drain_bits("ser2");
        check("ser2_empty_end", fifo_empty, 1'b1);

        set_role(3'b000);
        set_role(3'b101);
        for (int i = 1; i <= 5; i++) send(4'(i));
        check("fifo_full_at4", fifo_full, 1'b1);
        check("fifo_no_ovf_at4", overflow, 1'b0);
        check("fifo_not_empty", fifo_empty, 1'b0);
        repeat (12) tick();
        send(4'h7);
        check("push_pop_full", fifo_full, 1'b1);
        check("push_pop_no_ovf", overflow, 1'b0);
        send(4'h8);
        check("push_full_ovf", overflow, 1'b1);
        check("push_full_still", fifo_full, 1'b1);
        set_role(3'b000);
        check("inact_ovf_clr", overflow, 1'b0);
        check("inact_empty", fifo_empty, 1'b1);
        check("inact_full_clr", fifo_full, 1'b0);
        check("inact_mod", mod_type, 3'b000);

        set_role(3'b110);
        send(4'hF);
        check("to_enter_mod", mod_type, 3'b010);
        fired = 1'b0;
        k = 0;
`ifdef RELAY_FRAMER_TIMEOUT_EN
        while (!fired && k < 40) begin
            tick();
            k++;
            if (timeout === 1'b1) fired = 1'b1;
        end
        check("to_fired", fired, 1'b1);
        check("to_window", (k >= 15 && k <= 16), 1'b1);
        check("to_mod_listen", mod_type, 3'b001);
        tick();
        check("to_pulse_1cyc", timeout, 1'b0);
        check("to_mod_hold", mod_type, 3'b001);
`else
        while (k < 40) begin
            tick();
            k++;
            if (timeout !== 1'b0) fired = 1'b1;
        end
        check("noto_no_pulse", fired, 1'b0);
        check("noto_mod_stays", mod_type, 3'b010);
`endif

        set_role(3'b000);
        set_role(3'b101);
        send(4'hC);
        tick();
        tick();
        check("pre_rst_mod", mod_type, 3'b100);
        check("pre_rst_dout", data_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mod_type", mod_type, 3'b000);
        check("async_data_out", data_out, 1'b0);
        check("async_empty", fifo_empty, 1'b1);
        check("async_full", fifo_full, 1'b0);
        check("async_ovf", overflow, 1'b0);
        check("async_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_listen", mod_type, 3'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
